// File: rtl/ahb_to_isram_bridge.sv
// Zero-wait-state AHB-Lite slave in front of a byte-lane synchronous SRAM.
// Write data that collides with a read address phase is parked in a one-entry buffer.
module ahb_to_isram_bridge #(
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW+1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  logic          req;
  logic          rd_req;
  logic          wr_req;
  logic [3:0]    req_mask;
  logic [AW-1:0] req_addr;

  logic          wr_dp_q, wr_dp_d;
  logic          rd_dp_q, rd_dp_d;
  logic [AW-1:0] ap_addr_q, ap_addr_d;
  logic [3:0]    ap_mask_q, ap_mask_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          buf_pend_q, buf_pend_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_mask_q, buf_mask_d;
  logic [31:0]   buf_data_q, buf_data_d;

  logic          cs;
  logic [3:0]    wen;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          commit;
  logic          buf_load;
  logic          buf_hit;
  logic [31:0]   rdata_mrg;
  logic          unused_htrans;

  assign req      = HSEL & HREADY & HTRANS[1];
  assign rd_req   = req & ~HWRITE;
  assign wr_req   = req & HWRITE;
  assign req_addr = HADDR[AW+1:2];

  assign unused_htrans = HTRANS[0];

  always_comb begin
    unique case (HSIZE)
      3'd0:    req_mask = 4'b0001 << HADDR[1:0];
      3'd1:    req_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  // Port owner: read address phase, then direct write, then buffer commit.
  always_comb begin
    cs       = 1'b0;
    wen      = 4'b0000;
    addr     = req_addr;
    wdata    = HWDATA;
    commit   = 1'b0;
    buf_load = 1'b0;
    if (rd_req) begin
      cs       = 1'b1;
      buf_load = wr_dp_q;
    end else if (wr_dp_q) begin
      cs   = 1'b1;
      addr = ap_addr_q;
      wen  = ap_mask_q;
    end else if (buf_pend_q) begin
      cs     = 1'b1;
      addr   = buf_addr_q;
      wen    = buf_mask_q;
      wdata  = buf_data_q;
      commit = 1'b1;
    end
  end

  always_comb begin
    wr_dp_d    = wr_req;
    rd_dp_d    = rd_req;
    ap_addr_d  = wr_req ? req_addr : ap_addr_q;
    ap_mask_d  = wr_req ? req_mask : ap_mask_q;
    rd_addr_d  = rd_req ? req_addr : rd_addr_q;
    buf_pend_d = buf_pend_q;
    buf_addr_d = buf_addr_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    if (buf_load) begin
      buf_pend_d = 1'b1;
      buf_addr_d = ap_addr_q;
      buf_mask_d = ap_mask_q;
      buf_data_d = HWDATA;
    end else if (commit) begin
      buf_pend_d = 1'b0;
    end
  end

  // Buffer stays visible to reads through its own commit cycle.
  always_comb begin
    rdata_mrg = SRAMRDATA;
    buf_hit   = buf_pend_q & (rd_addr_q == buf_addr_q);
    for (int i = 0; i < 4; i++) begin
      if (buf_hit & buf_mask_q[i]) begin
        rdata_mrg[8*i +: 8] = buf_data_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_dp_q    <= 1'b0;
      rd_dp_q    <= 1'b0;
      buf_pend_q <= 1'b0;
    end else begin
      wr_dp_q    <= wr_dp_d;
      rd_dp_q    <= rd_dp_d;
      buf_pend_q <= buf_pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    ap_addr_q  <= ap_addr_d;
    ap_mask_q  <= ap_mask_d;
    rd_addr_q  <= rd_addr_d;
    buf_addr_q <= buf_addr_d;
    buf_mask_q <= buf_mask_d;
    buf_data_q <= buf_data_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(wr_dp_q && buf_pend_q && !rd_req));
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = (rd_dp_q & ~RST) ? rdata_mrg : 32'h0;
  assign SRAMCS    = cs & ~RST;
  assign SRAMWEN   = RST ? 4'b0000 : wen;
  assign SRAMADDR  = addr;
  assign SRAMWDATA = wdata;

endmodule

// File: tb/tb_ahb_to_isram_bridge.sv
// Bench for ahb_to_isram_bridge: directed cases plus random traffic
// checked every cycle against an architectural memory model.
module tb_ahb_to_isram_bridge;
  localparam int AW = 16;

  logic          CLK;
  logic          RST;
  logic          HSEL;
  logic          HREADY;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [AW+1:0] HADDR;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;

  ahb_to_isram_bridge #(.AW(AW)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
    .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sram[int];
  logic [31:0] arch[int];

  typedef struct {
    int          a;
    logic [3:0]  m;
    logic [31:0] d;
  } wr_t;
  wr_t deferred[$];

  function automatic logic [31:0] init_word(int a);
    logic [15:0] w;
    w = a[15:0];
    return {~w, w};
  endfunction

  function automatic logic [31:0] rd_sram(int a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_arch(int a);
    return arch.exists(a) ? arch[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] d,
                                        logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] lanes(logic [2:0] sz, logic [1:0] off);
    int nb;
    int lo;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    lo = int'(off) - (int'(off) % nb);
    return 4'(((1 << nb) - 1) << lo);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous SRAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (SRAMCS === 1'b1) begin
      if (|SRAMWEN)
        sram[int'(SRAMADDR)] = merge(rd_sram(int'(SRAMADDR)),
                                     SRAMWDATA, SRAMWEN);
      else
        SRAMRDATA <= rd_sram(int'(SRAMADDR));
    end
  end

  bit          m_rd_dp = 0;
  bit          m_wr_dp = 0;
  logic [31:0] m_rd_exp;
  int          m_wr_addr;
  logic [3:0]  m_wr_mask;

  always @(negedge CLK) begin
    bit rq, rdq, wrq;
    int wa;
    wr_t w;
    chk("hreadyout", 32'(HREADYOUT), 32'd1);
    chk("hresp", 32'(HRESP), 32'd0);
    if (RST) begin
      chk("rst_cs", 32'(SRAMCS), 32'd0);
      chk("rst_wen", 32'(SRAMWEN), 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      arch = sram;
      deferred.delete();
      m_rd_dp = 0;
      m_wr_dp = 0;
    end else begin
      rq  = HSEL && HREADY && HTRANS[1];
      rdq = rq && !HWRITE;
      wrq = rq && HWRITE;
      wa  = int'(HADDR[AW+1:2]);
      chk("hrdata", HRDATA, m_rd_dp ? m_rd_exp : 32'd0);
      if (rdq) begin
        chk("rd_cs", 32'(SRAMCS), 32'd1);
        chk("rd_wen", 32'(SRAMWEN), 32'd0);
        chk("rd_addr", 32'(SRAMADDR), 32'(wa));
      end else if (m_wr_dp) begin
        chk("wr_cs", 32'(SRAMCS), 32'd1);
        chk("wr_addr", 32'(SRAMADDR), 32'(m_wr_addr));
        chk("wr_wen", 32'(SRAMWEN), 32'(m_wr_mask));
        chk("wr_data", SRAMWDATA, HWDATA);
      end else if (deferred.size() > 0) begin
        w = deferred.pop_front();
        chk("cm_cs", 32'(SRAMCS), 32'd1);
        chk("cm_addr", 32'(SRAMADDR), 32'(w.a));
        chk("cm_wen", 32'(SRAMWEN), 32'(w.m));
        chk("cm_data", SRAMWDATA, w.d);
      end else begin
        chk("idle_cs", 32'(SRAMCS), 32'd0);
        chk("idle_wen", 32'(SRAMWEN), 32'd0);
      end
      if (m_wr_dp) begin
        arch[m_wr_addr] = merge(rd_arch(m_wr_addr), HWDATA, m_wr_mask);
        if (rdq) begin
          w.a = m_wr_addr;
          w.m = m_wr_mask;
          w.d = HWDATA;
          deferred.push_back(w);
        end
      end
      m_rd_dp = rdq;
      if (rdq) m_rd_exp = rd_arch(wa);
      m_wr_dp = wrq;
      m_wr_addr = wa;
      m_wr_mask = lanes(HSIZE, HADDR[1:0]);
    end
  end

  task automatic step(bit rst, bit sel, bit rdy, logic [1:0] tr,
                      bit wr, logic [2:0] sz, logic [AW+1:0] a,
                      logic [31:0] wd);
    @(posedge CLK);
    #1;
    RST    = rst;
    HSEL   = sel;
    HREADY = rdy;
    HTRANS = tr;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = a;
    HWDATA = wd;
    #2;
  endtask

  task automatic idle(logic [31:0] wd);
    step(0, 0, 1, 2'b00, 0, 3'd2, '0, wd);
  endtask

  task automatic wr(logic [AW+1:0] a, logic [2:0] sz, logic [31:0] wd);
    step(0, 1, 1, 2'b10, 1, sz, a, wd);
  endtask

  task automatic rd(logic [AW+1:0] a, logic [31:0] wd);
    step(0, 1, 1, 2'b10, 0, 3'd2, a, wd);
  endtask

  initial begin
    bit          sel, rdy, w;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [AW+1:0] a;
    RST = 1; HSEL = 0; HREADY = 1; HTRANS = 0; HWRITE = 0;
    HSIZE = 0; HADDR = 0; HWDATA = 0; SRAMRDATA = 0;
    step(1, 0, 1, 2'b00, 0, 3'd2, '0, 32'h0);
    step(1, 0, 1, 2'b00, 0, 3'd2, '0, 32'h0);
    chk("t0_cs", 32'(SRAMCS), 32'd0);
    chk("t0_hrdata", HRDATA, 32'd0);

    // 1: word write then read back
    wr(18'h10, 3'd2, 32'h0);
    idle(32'hDEADBEEF);
    chk("t1_cs", 32'(SRAMCS), 32'd1);
    chk("t1_addr", 32'(SRAMADDR), 32'd4);
    chk("t1_wen", 32'(SRAMWEN), 32'hF);
    idle(32'h0);
    rd(18'h10, 32'h0);
    idle(32'h0);
    chk("t1_rdata", HRDATA, 32'hDEADBEEF);

    // 2: byte and half writes
    wr(18'h13, 3'd0, 32'h0);
    wr(18'h14, 3'd1, 32'hAB000000);
    chk("t2_wen_b", 32'(SRAMWEN), 32'h8);
    idle(32'h00005566);
    chk("t2_wen_h", 32'(SRAMWEN), 32'h3);
    chk("t2_addr_h", 32'(SRAMADDR), 32'd5);
    rd(18'h10, 32'h0);
    rd(18'h14, 32'h0);
    chk("t2_rd_b", HRDATA, 32'hABADBEEF);
    idle(32'h0);
    chk("t2_rd_h", HRDATA, 32'hFFFA5566);

    // 3: write immediately followed by read of same word
    wr(18'h20, 3'd2, 32'h0);
    rd(18'h20, 32'h11223344);
    chk("t3_rd_cs", 32'(SRAMCS), 32'd1);
    chk("t3_rd_wen", 32'(SRAMWEN), 32'd0);
    chk("t3_rd_addr", 32'(SRAMADDR), 32'd8);
    idle(32'h0);
    chk("t3_merge", HRDATA, 32'h11223344);
    chk("t3_cm_wen", 32'(SRAMWEN), 32'hF);
    chk("t3_cm_addr", 32'(SRAMADDR), 32'd8);
    chk("t3_cm_data", SRAMWDATA, 32'h11223344);

    // 4: buffer held across three reads
    wr(18'h40, 3'd2, 32'h0);
    rd(18'h80, 32'hCAFEF00D);
    rd(18'h84, 32'h0);
    chk("t4_hold_wen", 32'(SRAMWEN), 32'd0);
    chk("t4_hold_addr", 32'(SRAMADDR), 32'h21);
    rd(18'h88, 32'h0);
    idle(32'h0);
    chk("t4_cm_wen", 32'(SRAMWEN), 32'hF);
    chk("t4_cm_addr", 32'(SRAMADDR), 32'h10);
    chk("t4_cm_data", SRAMWDATA, 32'hCAFEF00D);
    rd(18'h40, 32'h0);
    idle(32'h0);
    chk("t4_rdata", HRDATA, 32'hCAFEF00D);

    // 5: reset discards the buffered write
    wr(18'h30, 3'd2, 32'h0);
    rd(18'h30, 32'h55AA55AA);
    step(1, 0, 1, 2'b00, 0, 3'd2, '0, 32'h0);
    chk("t5_rst_cs", 32'(SRAMCS), 32'd0);
    chk("t5_rst_wen", 32'(SRAMWEN), 32'd0);
    chk("t5_rst_hrdata", HRDATA, 32'd0);
    idle(32'h0);
    chk("t5_no_commit", 32'(SRAMCS), 32'd0);
    rd(18'h30, 32'h0);
    idle(32'h0);
    chk("t5_rdata", HRDATA, 32'hFFF3000C);

    // 6: non-selected, BUSY and stalled transfers
    step(0, 0, 1, 2'b10, 1, 3'd2, 18'h50, 32'h0);
    chk("t6_nosel", 32'(SRAMCS), 32'd0);
    step(0, 1, 1, 2'b01, 1, 3'd2, 18'h50, 32'h0);
    chk("t6_busy", 32'(SRAMCS), 32'd0);
    step(0, 1, 0, 2'b10, 1, 3'd2, 18'h50, 32'h0);
    chk("t6_stall", 32'(SRAMCS), 32'd0);
    idle(32'h12345678);
    chk("t6_after", 32'(SRAMCS), 32'd0);
    chk("t6_resp", 32'(HRESP), 32'd0);

    // random traffic over a small window of words
    for (int i = 0; i < 3000; i++) begin
      sel = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      tr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1))
                                        : 2'($urandom_range(2, 3));
      w   = 1'($urandom_range(0, 1));
      sz  = 3'($urandom_range(0, 7));
      a   = 18'($urandom_range(0, 63));
      step((i % 700) == 699, sel, rdy, tr, w, sz, a, $urandom);
    end

    for (int i = 0; i < 3; i++) idle($urandom);
    for (int i = 0; i < 16; i++) rd(18'(i * 4), $urandom);
    for (int i = 0; i < 3; i++) idle($urandom);
    for (int i = 0; i < 16; i++)
      chk("final_mem", rd_sram(i), rd_arch(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
